// File: rtl/game_logic.sv
// Frame-based target game: two tracked player boxes chase a bouncing square target,
// scoring on overlap, and the result is composited over the camera pixel stream.
module game_logic #(
    parameter int H_ACT       = 640,
    parameter int V_ACT       = 480,
    parameter int TGT_SIZE    = 32,
    parameter int SPEED       = 4,
    parameter int GAME_FRAMES = 1800
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        predict_valid,
    input  logic        start,
    input  logic        enter_game,
    input  logic        ThisFrameEnd,
    input  logic [10:0] left  [2],
    input  logic [10:0] right [2],
    input  logic [10:0] up    [2],
    input  logic [10:0] down  [2],
    input  logic [10:0] x,
    input  logic [10:0] y,
    input  logic [7:0]  i_rgb [3],
    output logic [7:0]  o_rgb [3]
);

    localparam int TW = $clog2(GAME_FRAMES + 1);
    localparam logic [10:0] TX0 = 11'((H_ACT - TGT_SIZE) / 2);
    localparam logic [10:0] TY0 = 11'((V_ACT - TGT_SIZE) / 2);
    localparam logic signed [11:0] STEP  = 12'(SPEED);
    localparam logic signed [11:0] X_LIM = 12'(H_ACT - TGT_SIZE);
    localparam logic signed [11:0] Y_LIM = 12'(V_ACT - TGT_SIZE);
    localparam logic [11:0] TGT_W = 12'(TGT_SIZE);
    localparam logic [11:0] H_W   = 12'(H_ACT);

    typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

    state_t        state_q, state_d;
    logic [7:0]    score_q [2];
    logic [7:0]    score_d [2];
    logic [TW-1:0] timer_q, timer_d;
    logic [10:0]   left_q [2], right_q [2], up_q [2], down_q [2];
    logic [10:0]   left_d [2], right_d [2], up_d [2], down_d [2];
    logic [10:0]   tx_q, tx_d, ty_q, ty_d;
    logic          vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
    logic [15:0]   lfsr_q, lfsr_d;

    logic          box_valid [2];
    logic          hit [2];
    logic          on_box [2];
    logic [11:0]   tx_end, ty_end, xmove, ymove, bar0_end, bar1_start;
    logic          in_top, in_tgt;

    function automatic logic [7:0] sat_inc(input logic [7:0] s);
        return (s == 8'hFF) ? s : s + 8'd1;
    endfunction

    // Returns {moving_negative, new_position}; bounces off either wall.
    function automatic logic [11:0] move_axis(input logic [10:0] pos, input logic neg,
                                              input logic signed [11:0] lim);
        logic signed [11:0] sum;
        sum = $signed({1'b0, pos}) + (neg ? -STEP : STEP);
        if (sum > lim) return {1'b1, lim[10:0]};
        if (sum < 12'sd0) return {1'b0, 11'd0};
        return {neg, sum[10:0]};
    endfunction

    assign tx_end = {1'b0, tx_q} + TGT_W - 12'd1;
    assign ty_end = {1'b0, ty_q} + TGT_W - 12'd1;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            box_valid[p] = (left_q[p] <= right_q[p]) && (up_q[p] <= down_q[p]);
            hit[p] = box_valid[p] && ({1'b0, left_q[p]} <= tx_end) && (right_q[p] >= tx_q)
                     && ({1'b0, up_q[p]} <= ty_end) && (down_q[p] >= ty_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        timer_d  = timer_q;
        left_d   = left_q;
        right_d  = right_q;
        up_d     = up_q;
        down_d   = down_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        vx_neg_d = vx_neg_q;
        vy_neg_d = vy_neg_q;
        xmove    = '0;
        ymove    = '0;
        // Fibonacci LFSR, taps 16,14,13,11 in right-shift form
        lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

        if (predict_valid) begin
            left_d  = left;
            right_d = right;
            up_d    = up;
            down_d  = down;
        end

        case (state_q)
            IDLE: begin
                if (start && enter_game) begin
                    state_d  = PLAY;
                    score_d  = '{8'd0, 8'd0};
                    timer_d  = TW'(GAME_FRAMES);
                    tx_d     = TX0;
                    ty_d     = TY0;
                    vx_neg_d = 1'b0;
                    vy_neg_d = 1'b0;
                end
            end
            PLAY: begin
                if (!enter_game) begin
                    state_d = IDLE;
                end else if (ThisFrameEnd) begin
                    for (int p = 0; p < 2; p++) begin
                        if (hit[p]) score_d[p] = sat_inc(score_q[p]);
                    end
                    if (hit[0] || hit[1]) begin
                        tx_d     = {2'b0, lfsr_q[8:0]};
                        ty_d     = {3'b0, lfsr_q[15:8]} + 11'd64;
                        vx_neg_d = lfsr_q[0];
                        vy_neg_d = lfsr_q[1];
                    end else begin
                        xmove    = move_axis(tx_q, vx_neg_q, X_LIM);
                        ymove    = move_axis(ty_q, vy_neg_q, Y_LIM);
                        tx_d     = xmove[10:0];
                        vx_neg_d = xmove[11];
                        ty_d     = ymove[10:0];
                        vy_neg_d = ymove[11];
                    end
                    timer_d = timer_q - TW'(1);
                    if (timer_q == TW'(1)) state_d = OVER;
                end
            end
            OVER: begin
                if (!enter_game) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            score_q  <= '{8'd0, 8'd0};
            timer_q  <= '0;
            left_q   <= '{11'd0, 11'd0};
            right_q  <= '{11'd0, 11'd0};
            up_q     <= '{11'd0, 11'd0};
            down_q   <= '{11'd0, 11'd0};
            tx_q     <= TX0;
            ty_q     <= TY0;
            vx_neg_q <= 1'b0;
            vy_neg_q <= 1'b0;
            lfsr_q   <= 16'hACE1;
        end else begin
            state_q  <= state_d;
            score_q  <= score_d;
            timer_q  <= timer_d;
            left_q   <= left_d;
            right_q  <= right_d;
            up_q     <= up_d;
            down_q   <= down_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            vx_neg_q <= vx_neg_d;
            vy_neg_q <= vy_neg_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // Pixel compositor: score bars, box outlines, target, then camera.
    always_comb begin
        bar0_end   = {3'b0, score_q[0], 1'b0};
        bar1_start = H_W - {3'b0, score_q[1], 1'b0};
        in_top     = (y < 11'd8);
        in_tgt     = (x >= tx_q) && ({1'b0, x} < {1'b0, tx_q} + TGT_W)
                     && (y >= ty_q) && ({1'b0, y} < {1'b0, ty_q} + TGT_W);
        for (int p = 0; p < 2; p++) begin
            on_box[p] = box_valid[p] &&
                        ((((x == left_q[p]) || (x == right_q[p])) && (y >= up_q[p]) && (y <= down_q[p])) ||
                         (((y == up_q[p]) || (y == down_q[p])) && (x >= left_q[p]) && (x <= right_q[p])));
        end

        if (state_q == OVER) begin
            for (int c = 0; c < 3; c++) o_rgb[c] = i_rgb[c] >> 1;
        end else begin
            o_rgb = i_rgb;
        end

        if (state_q != IDLE && in_top && ({1'b0, x} < bar0_end)) begin
            o_rgb = '{8'hFF, 8'hFF, 8'h00};
        end else if (state_q != IDLE && in_top && ({1'b0, x} >= bar1_start)) begin
            o_rgb = '{8'h00, 8'hFF, 8'hFF};
        end else if (state_q != OVER && on_box[0]) begin
            o_rgb = '{8'h00, 8'hFF, 8'h00};
        end else if (state_q != OVER && on_box[1]) begin
            o_rgb = '{8'h00, 8'h00, 8'hFF};
        end else if (state_q == PLAY && in_tgt) begin
            o_rgb = '{8'hFF, 8'h00, 8'h00};
        end
    end

endmodule

// File: tb/tb_game_logic.sv
// Directed bench for game_logic: hand-computed pixel vectors plus a small behavioural
// game model for the multi-frame sequences.
module tb_game_logic;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pv, start, enter, tfe;
    logic [10:0] l_i [2], r_i [2], u_i [2], d_i [2];
    logic [10:0] px, py;
    logic [7:0]  rgb_i [3], rgb_o [3];

    always #5 clk = ~clk;

    game_logic dut (
        .i_clk(clk), .i_rst_n(rst_n), .predict_valid(pv), .start(start),
        .enter_game(enter), .ThisFrameEnd(tfe),
        .left(l_i), .right(r_i), .up(u_i), .down(d_i),
        .x(px), .y(py), .i_rgb(rgb_i), .o_rgb(rgb_o)
    );

    localparam logic [23:0] CAM = 24'h0A141E, DIM = 24'h050A0F;
    localparam logic [23:0] RED = 24'hFF0000, GRN = 24'h00FF00, BLU = 24'h0000FF;
    localparam logic [23:0] YEL = 24'hFFFF00, CYA = 24'h00FFFF;
    localparam int S_IDLE = 0, S_PLAY = 1, S_OVER = 2;

    int checks = 0;
    int errors = 0;

    int m_state, m_s0, m_s1, m_tx, m_ty, m_timer;
    bit m_vxn, m_vyn;
    int mb_l [2], mb_r [2], mb_u [2], mb_d [2];
    logic [15:0] m_lfsr;

    always @(posedge clk) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    function automatic bit m_valid(int p);
        return (mb_l[p] <= mb_r[p]) && (mb_u[p] <= mb_d[p]);
    endfunction

    function automatic bit m_hit(int p);
        return m_valid(p) && mb_l[p] <= m_tx + 31 && mb_r[p] >= m_tx
               && mb_u[p] <= m_ty + 31 && mb_d[p] >= m_ty;
    endfunction

    function automatic bit m_outline(int p, int qx, int qy);
        bit vert, horz;
        vert = (qx == mb_l[p] || qx == mb_r[p]) && qy >= mb_u[p] && qy <= mb_d[p];
        horz = (qy == mb_u[p] || qy == mb_d[p]) && qx >= mb_l[p] && qx <= mb_r[p];
        return m_valid(p) && (vert || horz);
    endfunction

    function automatic logic [23:0] ref_pixel(int qx, int qy);
        if (m_state != S_IDLE && qy < 8 && qx < 2 * m_s0) return YEL;
        if (m_state != S_IDLE && qy < 8 && qx >= 640 - 2 * m_s1) return CYA;
        if (m_state != S_OVER && m_outline(0, qx, qy)) return GRN;
        if (m_state != S_OVER && m_outline(1, qx, qy)) return BLU;
        if (m_state == S_PLAY && qx >= m_tx && qx < m_tx + 32 && qy >= m_ty && qy < m_ty + 32)
            return RED;
        return (m_state == S_OVER) ? DIM : CAM;
    endfunction

    task automatic axis(inout int pos, inout bit neg, input int lim);
        if (neg && pos < 4) begin
            pos = 0;
            neg = 1'b0;
        end else begin
            pos = pos + (neg ? -4 : 4);
            if (pos > lim) begin
                pos = lim;
                neg = 1'b1;
            end
        end
    endtask

    task automatic model_frame(input logic [15:0] lf);
        bit h0, h1;
        if (m_state == S_PLAY) begin
            h0 = m_hit(0);
            h1 = m_hit(1);
            if (h0 && m_s0 < 255) m_s0++;
            if (h1 && m_s1 < 255) m_s1++;
            if (h0 || h1) begin
                m_tx  = int'(lf[8:0]);
                m_ty  = int'(lf[15:8]) + 64;
                m_vxn = lf[0];
                m_vyn = lf[1];
            end else begin
                axis(m_tx, m_vxn, 608);
                axis(m_ty, m_vyn, 448);
            end
            if (m_timer == 1) m_state = S_OVER;
            m_timer--;
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_s0 = 0; m_s1 = 0; m_timer = 0;
        m_tx = 304; m_ty = 224; m_vxn = 1'b0; m_vyn = 1'b0;
        for (int p = 0; p < 2; p++) begin
            mb_l[p] = 0; mb_r[p] = 0; mb_u[p] = 0; mb_d[p] = 0;
        end
    endtask

    task automatic model_enter_play();
        m_state = S_PLAY; m_s0 = 0; m_s1 = 0; m_timer = 1800;
        m_tx = 304; m_ty = 224; m_vxn = 1'b0; m_vyn = 1'b0;
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: o_rgb=%h expected %h", name, act, exp);
        end
    endtask

    task automatic probe_exp(input int qx, input int qy, input logic [23:0] exp, input string name);
        @(negedge clk);
        px = 11'(qx);
        py = 11'(qy);
        #1;
        chk(name, {rgb_o[0], rgb_o[1], rgb_o[2]}, exp);
    endtask

    task automatic probe_model(input int qx, input int qy, input string name);
        probe_exp(qx, qy, ref_pixel(qx, qy), name);
    endtask

    task automatic check_target(input string name);
        probe_model(m_tx, m_ty, {name, "_tl"});
        probe_model(m_tx + 31, m_ty + 31, {name, "_br"});
        probe_model(m_tx + 32, m_ty, {name, "_out"});
    endtask

    task automatic frame();
        logic [15:0] lf;
        @(negedge clk);
        lf  = m_lfsr;
        tfe = 1'b1;
        @(negedge clk);
        tfe = 1'b0;
        model_frame(lf);
    endtask

    task automatic drive_edges(input int l0, input int r0, input int u0, input int d0,
                               input int l1, input int r1, input int u1, input int d1);
        l_i[0] = 11'(l0); r_i[0] = 11'(r0); u_i[0] = 11'(u0); d_i[0] = 11'(d0);
        l_i[1] = 11'(l1); r_i[1] = 11'(r1); u_i[1] = 11'(u1); d_i[1] = 11'(d1);
    endtask

    task automatic set_boxes(input int l0, input int r0, input int u0, input int d0,
                             input int l1, input int r1, input int u1, input int d1);
        @(negedge clk);
        drive_edges(l0, r0, u0, d0, l1, r1, u1, d1);
        pv = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        mb_l[0] = l0; mb_r[0] = r0; mb_u[0] = u0; mb_d[0] = d0;
        mb_l[1] = l1; mb_r[1] = r1; mb_u[1] = u1; mb_d[1] = d1;
    endtask

    task automatic start_game();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_enter_play();
    endtask

    task automatic leave_game();
        @(negedge clk);
        enter = 1'b0;
        @(negedge clk);
        enter = 1'b1;
        m_state = S_IDLE;
    endtask

    typedef struct {
        int          x;
        int          y;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int ox, old_tx, old_ty;
        logic [15:0] lf;

        tbl[0] = '{320, 240, RED};
        tbl[1] = '{100, 100, GRN};
        tbl[2] = '{304, 224, RED};
        tbl[3] = '{303, 224, CAM};
        tbl[4] = '{335, 255, RED};
        tbl[5] = '{336, 255, CAM};
        tbl[6] = '{304, 256, CAM};
        tbl[7] = '{101, 100, CAM};
        tbl[8] = '{0,   0,   CAM};
        tbl[9] = '{639, 0,   CAM};

        pv = 1'b0; start = 1'b1; enter = 1'b1; tfe = 1'b0;
        px = '0; py = '0;
        rgb_i = '{8'd10, 8'd20, 8'd30};
        drive_edges(100, 100, 100, 100, 100, 100, 100, 100);
        model_reset();

        // Reset held with start requested: stays IDLE, boxes cleared to a point at origin.
        repeat (2) @(negedge clk);
        probe_exp(0, 0, GRN, "rst_box_origin");
        probe_exp(320, 240, CAM, "rst_idle_no_target");

        @(negedge clk);
        rst_n = 1'b1;
        pv    = 1'b1;
        @(negedge clk);
        pv    = 1'b0;
        start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            mb_l[p] = 100; mb_r[p] = 100; mb_u[p] = 100; mb_d[p] = 100;
        end
        model_enter_play();

        for (int i = 0; i < 10; i++)
            probe_exp(tbl[i].x, tbl[i].y, tbl[i].exp, $sformatf("vec%0d", i));

        // Two frames of plain motion, then box0 moved onto the target.
        frame();
        frame();
        probe_exp(312, 232, RED, "move2_tl");
        probe_exp(311, 232, CAM, "move2_left");
        probe_exp(1, 3, CAM, "no_score_yet");
        set_boxes(300, 340, 220, 260, 100, 100, 100, 100);
        frame();
        probe_exp(1, 3, YEL, "score0_is1");
        probe_exp(2, 3, CAM, "score0_bar_end");
        check_target("reloc1");

        // Both players cover the target in the same frame.
        set_boxes(0, 639, 0, 479, 0, 639, 0, 479);
        frame();
        probe_exp(3, 3, YEL, "both_s0");
        probe_exp(4, 3, CAM, "both_s0_end");
        probe_exp(638, 3, CYA, "both_s1");
        probe_exp(637, 3, CAM, "both_s1_end");
        check_target("reloc2");

        // Edges change without predict_valid: held point boxes, no score.
        set_boxes(639, 639, 479, 479, 639, 639, 479, 479);
        @(negedge clk);
        drive_edges(0, 639, 0, 479, 0, 639, 0, 479);
        frame();
        probe_exp(3, 3, YEL, "hold_s0");
        probe_exp(4, 3, CAM, "hold_s0_end");
        probe_model(0, 240, "hold_no_outline");

        // left>right: never scores, never drawn.
        set_boxes(400, 100, 0, 479, 400, 100, 0, 479);
        frame();
        probe_exp(4, 3, CAM, "inv_no_score");
        probe_model(400, 240, "inv_no_outline_l");
        probe_model(100, 240, "inv_no_outline_r");
        check_target("inv_move");

        // Back to IDLE: no bars, no target; then a fresh game walks to the right wall.
        leave_game();
        probe_exp(3, 3, CAM, "idle_no_bars");
        probe_exp(m_tx, m_ty, CAM, "idle_no_target");
        start_game();
        for (int i = 0; i < 76; i++) frame();
        probe_exp(608, m_ty, RED, "wall_reach");
        probe_exp(607, m_ty, CAM, "wall_reach_left");
        frame();
        probe_exp(608, m_ty, RED, "wall_clamp");
        frame();
        probe_exp(604, m_ty, RED, "wall_bounce");
        probe_exp(603, m_ty, CAM, "wall_bounce_left");
        probe_exp(636, m_ty, CAM, "wall_bounce_right");

        // Score saturation with box0 covering the whole screen.
        set_boxes(0, 639, 0, 479, 1, 0, 1, 0);
        for (int i = 0; i < 255; i++) frame();
        probe_exp(509, 3, YEL, "sat_255");
        probe_exp(510, 3, CAM, "sat_255_end");
        frame();
        probe_exp(509, 3, YEL, "sat_hold");
        probe_exp(510, 3, CAM, "sat_hold_end");
        probe_exp(1, 3, YEL, "sat_no_wrap");

        // Frame end held high for a whole game.
        set_boxes(1, 0, 1, 0, 1, 0, 1, 0);
        leave_game();
        start_game();
        @(negedge clk);
        tfe = 1'b1;
        for (int i = 0; i < 1799; i++) begin
            lf = m_lfsr;
            @(negedge clk);
            model_frame(lf);
        end
        tfe = 1'b0;
        ox = (m_tx >= 320) ? 0 : 639;
        probe_exp(ox, 240, CAM, "still_play_1799");
        probe_model(m_tx, m_ty, "target_1799");
        frame();
        probe_exp(ox, 240, DIM, "over_dim");
        probe_exp(m_tx, m_ty, DIM, "over_no_target");
        probe_exp(0, 3, DIM, "over_bar_empty");
        leave_game();
        probe_exp(0, 240, CAM, "over_to_idle");

        // Reset mid-game.
        start_game();
        frame();
        old_tx = m_tx;
        old_ty = m_ty;
        probe_exp(old_tx, old_ty, RED, "pre_midrst_target");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        probe_exp(old_tx, old_ty, CAM, "midrst_idle");
        probe_exp(0, 0, GRN, "midrst_boxes_zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
